muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Sequences the shared multiplier and divider units on behalf of the main control FSM.
- Issues the unit start pulses and holds the operand-source selects (DivSrcA/DivSrcB) and result-source selects (HiCtrl/LoCtrl) for the whole operation.
- Counts the fixed unit latency, then writes Hi/Lo or raises a divide-by-zero exception.
- Provides a busy/done handshake and a Hi/Lo read interlock, so the main FSM only issues a start and waits for done.

Parameters:
- MULT_LAT, 32, cycles from mult_ctrl pulse until multiplier Hi/Lo outputs are valid.
- DIV_LAT, 32, cycles from div_ctrl pulse until divider Hi/Lo outputs are valid.
- CNT_W, 6, latency counter width; must hold max(MULT_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from main control.
- op  in  2  00 mult (A*B), 01 div (A/B), 10 divm (RegDiv/MDR), 11 reserved.
- cancel  in  1  abort current operation (exception elsewhere).
- divzero  in  1  divider divide-by-zero flag.
- hilo_rd_req  in  1  main FSM wants to read Hi or Lo (mfhi/mflo).
- mult_ctrl  out  1  multiplier start pulse.
- div_ctrl  out  1  divider start pulse.
- div_src_a  out  1  0 = RegDiv, 1 = RegA.
- div_src_b  out  1  0 = RegB, 1 = MDR.
- hi_ctrl  out  1  0 = divider Hi, 1 = multiplier Hi.
- lo_ctrl  out  1  0 = divider Lo, 1 = multiplier Lo.
- hi_w  out  1  Hi register load.
- lo_w  out  1  Lo register load.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- divzero_exc  out  1  one-cycle exception pulse.
- hilo_stall  out  1  hilo_rd_req & busy (combinational).

Behaviour:
- Reset (reset=0, any time, mid-operation included):
  - state IDLE, counter 0, latched op 00.
  - All outputs 0.
  - No Hi/Lo write is ever issued for an interrupted operation.
- States: IDLE, LAUNCH, WAIT, WRITE, EXC.
- IDLE: busy=0.
  - start=1 with op != 11: latch op, go to LAUNCH.
  - start with op=11: ignored, stay IDLE, no done.
- LAUNCH (1 cycle): busy=1.
  - mult_ctrl=1 if op=mult, else div_ctrl=1.
  - Counter loaded with MULT_LAT-1 or DIV_LAT-1.
  - Go to WAIT.
- WAIT: busy=1, counter decrements each cycle.
  - Div ops only: divzero=1 in any WAIT cycle goes to EXC. divzero is ignored for mult.
  - counter==0 goes to WRITE.
- WRITE (1 cycle): busy=1, hi_w=lo_w=1, done=1, then IDLE.
  - Hi/Lo hold the new value in the cycle after done.
- EXC (1 cycle): busy=1, divzero_exc=1, hi_w=lo_w=0, no done, then IDLE.
- Latency: start sampled at edge N gives done high in cycle N+LAT+2 (LAUNCH + LAT WAIT cycles + WRITE).
- Selects are decoded from the latched op and held stable in LAUNCH, WAIT and WRITE:
  - mult: hi_ctrl=lo_ctrl=1.
  - div: div_src_a=1, div_src_b=0, hi_ctrl=lo_ctrl=0.
  - divm: div_src_a=0, div_src_b=1, hi_ctrl=lo_ctrl=0.
  - All selects are 0 in IDLE.
- cancel=1 in any non-IDLE state:
  - next state IDLE;
  - hi_w, lo_w, done and divzero_exc are combinationally forced 0 in that cycle (cancel has priority in WRITE/EXC).
  - cancel in IDLE has no effect.
- start while busy: ignored, no queueing; the current op is unaffected.
- start and cancel in the same IDLE cycle: start is accepted.
- start in the same cycle as done (WRITE): ignored; the requester re-issues after done.
- hilo_stall: asserted whenever busy=1 and hilo_rd_req=1, including the WRITE cycle. It deasserts the cycle after WRITE, when Hi/Lo are valid.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULT, OP_DIV, OP_DIVM, OP_RSVD), state encoding, default latency constants.
- Sub-module muldiv_lat_counter: loadable down-counter with load, value, enable and zero flag.
- The FSM and output decode stay in muldiv_sequencer.

Test Plan:
- Mult: start, op=00 at cycle 0 -> mult_ctrl pulse in cycle 1, busy cycles 1..34, hi_w=lo_w=done=1 with hi_ctrl=lo_ctrl=1 in cycle 34, busy=0 in cycle 35.
- divm: op=10 -> div_ctrl pulse in cycle 1, div_src_a=0 and div_src_b=1 held cycles 1..34, hi_ctrl=lo_ctrl=0 during the write cycle.
- Divide by zero: op=01 with divzero=1 in WAIT cycle 5 -> divzero_exc=1 in cycle 6, no hi_w/lo_w/done, IDLE in cycle 7.
- Cancel: cancel in cycle 20 of a div -> IDLE in cycle 21, no write/done. Cancel during WRITE -> hi_w=lo_w=done=0.
- Interlock: hilo_rd_req held from cycle 3 -> hilo_stall=1 through the write cycle, 0 the cycle after. A second start in cycle 10 -> ignored, single done.
- Reset mid-op and reserved op: reset low in cycle 15 -> all outputs 0 immediately, no write after release. op=11 start -> busy remains 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding, default unit latencies and the select decode helper.
package muldiv_pkg;

    // Default fixed latencies of the shared arithmetic units
    localparam int MULT_LAT_DEF = 32;
    localparam int DIV_LAT_DEF  = 32;
    // Counter must hold max(MULT_LAT, DIV_LAT) - 1
    localparam int CNT_W_DEF    = 6;

    // Operation requested by the main control FSM
    typedef enum logic [1:0] {
        OP_MULT = 2'b00,   // Hi/Lo <= A * B
        OP_DIV  = 2'b01,   // Hi/Lo <= A / B
        OP_DIVM = 2'b10,   // Hi/Lo <= RegDiv / MDR
        OP_RSVD = 2'b11    // not a valid request, ignored
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_EXC    = 3'd4
    } state_e;

    // Operand and result source selects driven while an operation is active
    typedef struct packed {
        logic div_src_a;   // 0 = RegDiv, 1 = RegA
        logic div_src_b;   // 0 = RegB,   1 = MDR
        logic hi_ctrl;     // 0 = divider Hi, 1 = multiplier Hi
        logic lo_ctrl;     // 0 = divider Lo, 1 = multiplier Lo
    } sel_t;

    // True for the operations that run on the divider
    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVM);
    endfunction

    // Select pattern for a latched operation
    function automatic sel_t decode_sel(input op_e op);
        sel_t sel;
        sel = '0;
        case (op)
            OP_MULT: begin
                sel.hi_ctrl = 1'b1;
                sel.lo_ctrl = 1'b1;
            end
            OP_DIV: begin
                sel.div_src_a = 1'b1;
                sel.div_src_b = 1'b0;
            end
            OP_DIVM: begin
                sel.div_src_a = 1'b0;
                sel.div_src_b = 1'b1;
            end
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/muldiv_lat_counter.sv
// Loadable down-counter used to time the fixed latency of the arithmetic
// units. Holds at zero once it gets there; zero flag is combinational.
module muldiv_lat_counter
    import muldiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] value_reg;

    // Load has priority over counting; counting stops at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_value;
        end else if (enable && (value_reg != '0)) begin
            value_reg <= value_reg - 1'b1;
        end
    end

    // Terminal count flag
    always_comb begin
        zero = (value_reg == '0);
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider for the main control FSM: issues
// the unit start pulse, holds the operand/result selects, waits the unit
// latency and then either loads Hi/Lo or raises a divide-by-zero exception.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       cancel,
    input  logic       divzero,
    input  logic       hilo_rd_req,
    output logic       mult_ctrl,
    output logic       div_ctrl,
    output logic       div_src_a,
    output logic       div_src_b,
    output logic       hi_ctrl,
    output logic       lo_ctrl,
    output logic       hi_w,
    output logic       lo_w,
    output logic       busy,
    output logic       done,
    output logic       divzero_exc,
    output logic       hilo_stall
);

    // Counter reload values: LAUNCH loads LAT-1 so WAIT lasts exactly LAT cycles
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    state_e           state_reg;
    state_e           state_next;
    op_e              op_reg;
    op_e              op_in;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_en;
    logic             cnt_zero;
    sel_t             sel;
    logic             active;

    assign op_in = op_e'(op);

    muldiv_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .enable     (cnt_en),
        .zero       (cnt_zero)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the operation when a request is accepted so selects stay stable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg <= OP_MULT;
        end else if (accept) begin
            op_reg <= op_in;
        end
    end

    // Next-state logic and latency counter control
    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_en         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Reserved op is dropped silently; cancel has no meaning here
                if (start && (op_in != OP_RSVD)) begin
                    accept     = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_load       = 1'b1;
                cnt_load_value = (op_reg == OP_MULT) ? MULT_LOAD : DIV_LOAD;
                state_next     = ST_WAIT;
            end
            ST_WAIT: begin
                // A divider fault wins over normal completion in the same cycle
                if (is_div_op(op_reg) && divzero) begin
                    state_next = ST_EXC;
                end else if (cnt_zero) begin
                    state_next = ST_WRITE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WRITE: begin
                // A start seen here is not queued; requester re-issues after done
                state_next = ST_IDLE;
            end
            ST_EXC: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort from anywhere outside IDLE
        if ((state_reg != ST_IDLE) && cancel) begin
            state_next = ST_IDLE;
        end
    end

    // Output decode: pulses from state, selects from latched op, cancel gates side effects
    always_comb begin
        active      = (state_reg != ST_IDLE);
        busy        = active;
        mult_ctrl   = (state_reg == ST_LAUNCH) && (op_reg == OP_MULT);
        div_ctrl    = (state_reg == ST_LAUNCH) && is_div_op(op_reg);
        sel         = active ? decode_sel(op_reg) : '0;
        div_src_a   = sel.div_src_a;
        div_src_b   = sel.div_src_b;
        hi_ctrl     = sel.hi_ctrl;
        lo_ctrl     = sel.lo_ctrl;
        hi_w        = (state_reg == ST_WRITE) && !cancel;
        lo_w        = (state_reg == ST_WRITE) && !cancel;
        done        = (state_reg == ST_WRITE) && !cancel;
        divzero_exc = (state_reg == ST_EXC) && !cancel;
        // Hi/Lo are not valid until the cycle after WRITE
        hilo_stall  = hilo_rd_req && active;
    end

endmodule
